// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/comparator.
// Provides the opcode and flagMode encodings and the function that turns
// the propagated compare results (eq, ltu, lts) into the selected flag.
package adder_pkg;

    localparam int unsigned OPCODE_W = 2;
    localparam int unsigned FLAG_W   = 4;

    // Opcodes; 2'b01 is also treated as a plain add
    localparam logic [OPCODE_W-1:0] ADD  = 2'b00;
    localparam logic [OPCODE_W-1:0] ADDC = 2'b10;
    localparam logic [OPCODE_W-1:0] SUB  = 2'b11;

    // Compare selects
    localparam logic [FLAG_W-1:0] FLAG_EQ  = 4'b0000;
    localparam logic [FLAG_W-1:0] FLAG_NE  = 4'b0001;
    localparam logic [FLAG_W-1:0] FLAG_GTU = 4'b0010;
    localparam logic [FLAG_W-1:0] FLAG_GEU = 4'b0011;
    localparam logic [FLAG_W-1:0] FLAG_LTU = 4'b0100;
    localparam logic [FLAG_W-1:0] FLAG_LEU = 4'b0101;
    localparam logic [FLAG_W-1:0] FLAG_GTS = 4'b1010;
    localparam logic [FLAG_W-1:0] FLAG_GES = 4'b1011;
    localparam logic [FLAG_W-1:0] FLAG_LTS = 4'b1100;
    localparam logic [FLAG_W-1:0] FLAG_LES = 4'b1101;

    // Select one compare outcome; unlisted modes pass the captured flagIn through
    function automatic logic flag_decode(
        input logic [FLAG_W-1:0] mode,
        input logic              eq,
        input logic              ltu,
        input logic              lts,
        input logic              pass
    );
        logic flag;
        flag = pass;
        case (mode)
            FLAG_EQ:  flag = eq;
            FLAG_NE:  flag = ~eq;
            FLAG_GTU: flag = ~ltu & ~eq;
            FLAG_GEU: flag = ~ltu;
            FLAG_LTU: flag = ltu;
            FLAG_LEU: flag = ltu | eq;
            FLAG_GTS: flag = ~lts & ~eq;
            FLAG_GES: flag = ~lts;
            FLAG_LTS: flag = lts;
            FLAG_LES: flag = lts | eq;
            default:  flag = pass;
        endcase
        return flag;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// One carry segment of the pipelined adder (combinational).
// Ports:
//   a, b    - operand segments (b is the original, un-inverted operand)
//   beff    - effective B segment fed to the adder
//   cin     - carry into this segment
//   sum     - segment sum, cout - carry out of the segment
//   segEq   - a == b, segLtu - a < b unsigned
//   segLts  - a < b signed in the top segment, same as segLtu elsewhere
module adder_segment #(
    parameter int unsigned SEG = 16,
    parameter bit          TOP = 1'b0
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic [SEG-1:0] beff,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           segEq,
    output logic           segLtu,
    output logic           segLts
);

    assign {cout, sum} = {1'b0, a} + {1'b0, beff} + {{SEG{1'b0}}, cin};
    assign segEq       = (a == b);
    assign segLtu      = (a < b);

    // Only the most significant segment carries a sign bit
    if (TOP) begin : g_signed
        assign segLts = ($signed(a) < $signed(b));
    end else begin : g_unsigned
        assign segLts = segLtu;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add / add-with-carry / subtract with compare flags.
// The WIDTH-bit datapath is cut into STAGES carry segments, one per clock.
// Ports:
//   clock, reset (sync, active-high)
//   validIn, stall, flush         - pipeline handshake
//   opcode, flagMode, flagIn, carryIn, operantA, operantB - operation
//   validOut, result, carryOut, overflowOut, flagOut       - registered result
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                validIn,
    input  logic                stall,
    input  logic                flush,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FLAG_W-1:0]   flagMode,
    input  logic                flagIn,
    input  logic                carryIn,
    input  logic [WIDTH-1:0]    operantA,
    input  logic [WIDTH-1:0]    operantB,
    output logic                validOut,
    output logic [WIDTH-1:0]    result,
    output logic                carryOut,
    output logic                overflowOut,
    output logic                flagOut
);

    localparam int unsigned SEG = WIDTH / STAGES;

    // Entry decode: subtract is A + ~B + 1
    logic [WIDTH-1:0] beff_in;
    logic             cin_in;

    assign beff_in = (opcode == SUB) ? ~operantB : operantB;
    assign cin_in  = (opcode == SUB) | ((opcode == ADDC) & carryIn);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // LO: bits finished by earlier stages; UP: bits still waiting after this one
        localparam int unsigned LO = k * SEG;
        localparam int unsigned UP = WIDTH - (k + 1) * SEG;

        logic [SEG-1:0]    a_s, b_s, beff_s, sum;
        logic              cin_s, eq_lo, ltu_lo, lts_lo, v_s, fi_s;
        logic [FLAG_W-1:0] fm_s;
        logic              cout, seg_eq, seg_ltu, seg_lts;
        logic              eq_n, ltu_n, lts_n;

        // Stage inputs: the ports for the first stage, the skew registers otherwise
        if (k == 0) begin : g_in
            assign a_s    = operantA[SEG-1:0];
            assign b_s    = operantB[SEG-1:0];
            assign beff_s = beff_in[SEG-1:0];
            assign cin_s  = cin_in;
            assign eq_lo  = 1'b1;
            assign ltu_lo = 1'b0;
            assign lts_lo = 1'b0;
            assign v_s    = validIn;
            assign fm_s   = flagMode;
            assign fi_s   = flagIn;
        end else begin : g_in
            assign a_s    = g_stage[k-1].g_mid.a_r[SEG-1:0];
            assign b_s    = g_stage[k-1].g_mid.b_r[SEG-1:0];
            assign beff_s = g_stage[k-1].g_mid.beff_r[SEG-1:0];
            assign cin_s  = g_stage[k-1].g_mid.c_r;
            assign eq_lo  = g_stage[k-1].g_mid.eq_r;
            assign ltu_lo = g_stage[k-1].g_mid.ltu_r;
            assign lts_lo = g_stage[k-1].g_mid.lts_r;
            assign v_s    = g_stage[k-1].g_mid.v_r;
            assign fm_s   = g_stage[k-1].g_mid.fm_r;
            assign fi_s   = g_stage[k-1].g_mid.fi_r;
        end

        adder_segment #(
            .SEG (SEG),
            .TOP (k == STAGES - 1)
        ) u_seg (
            .a      (a_s),
            .b      (b_s),
            .beff   (beff_s),
            .cin    (cin_s),
            .sum    (sum),
            .cout   (cout),
            .segEq  (seg_eq),
            .segLtu (seg_ltu),
            .segLts (seg_lts)
        );

        // Compare merge: a higher segment decides unless it is equal
        assign eq_n  = seg_eq & eq_lo;
        assign ltu_n = seg_ltu | (seg_eq & ltu_lo);
        assign lts_n = seg_lts | (seg_eq & lts_lo);

        if (k < STAGES - 1) begin : g_mid
            logic [UP-1:0]     a_r, b_r, beff_r;
            logic [UP-1:0]     a_up, b_up, beff_up;
            logic [LO+SEG-1:0] res_r, res_n;
            logic              v_r, c_r, eq_r, ltu_r, lts_r, fi_r;
            logic [FLAG_W-1:0] fm_r;

            if (k == 0) begin : g_src
                assign a_up    = operantA[WIDTH-1:SEG];
                assign b_up    = operantB[WIDTH-1:SEG];
                assign beff_up = beff_in[WIDTH-1:SEG];
                assign res_n   = sum;
            end else begin : g_src
                assign a_up    = g_stage[k-1].g_mid.a_r[WIDTH-LO-1:SEG];
                assign b_up    = g_stage[k-1].g_mid.b_r[WIDTH-LO-1:SEG];
                assign beff_up = g_stage[k-1].g_mid.beff_r[WIDTH-LO-1:SEG];
                assign res_n   = {sum, g_stage[k-1].g_mid.res_r};
            end

            // Skew and partial-result register; flush clears valid even under stall
            always_ff @(posedge clock) begin
                if (reset) begin
                    v_r    <= 1'b0;
                    a_r    <= '0;
                    b_r    <= '0;
                    beff_r <= '0;
                    res_r  <= '0;
                    c_r    <= 1'b0;
                    eq_r   <= 1'b0;
                    ltu_r  <= 1'b0;
                    lts_r  <= 1'b0;
                    fm_r   <= '0;
                    fi_r   <= 1'b0;
                end else begin
                    if (flush) begin
                        v_r <= 1'b0;
                    end else if (!stall) begin
                        v_r <= v_s;
                    end
                    if (!stall) begin
                        a_r    <= a_up;
                        b_r    <= b_up;
                        beff_r <= beff_up;
                        res_r  <= res_n;
                        c_r    <= cout;
                        eq_r   <= eq_n;
                        ltu_r  <= ltu_n;
                        lts_r  <= lts_n;
                        fm_r   <= fm_s;
                        fi_r   <= fi_s;
                    end
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] res_full;
            logic             ovf;

            if (k == 0) begin : g_res
                assign res_full = sum;
            end else begin : g_res
                assign res_full = {sum, g_stage[k-1].g_mid.res_r};
            end

            // Signed overflow: operands agree in sign, result does not
            assign ovf = (a_s[SEG-1] == beff_s[SEG-1]) & (sum[SEG-1] != a_s[SEG-1]);

            // Output register
            always_ff @(posedge clock) begin
                if (reset) begin
                    validOut    <= 1'b0;
                    result      <= '0;
                    carryOut    <= 1'b0;
                    overflowOut <= 1'b0;
                    flagOut     <= 1'b0;
                end else begin
                    if (flush) begin
                        validOut <= 1'b0;
                    end else if (!stall) begin
                        validOut <= v_s;
                    end
                    if (!stall) begin
                        result      <= res_full;
                        carryOut    <= cout;
                        overflowOut <= ovf;
                        flagOut     <= flag_decode(fm_s, eq_n, ltu_n, lts_n, fi_s);
                    end
                end
            end
        end
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor of the OR1420 single-cycle adder/comparator. Computes add, add-with-carry and subtract over a WIDTH-bit datapath split into STAGES carry segments, one segment per clock, and evaluates the same set of compare flags with an incrementally propagated segment comparison. Adds registered outputs, a valid/stall/flush pipeline handshake and a signed-overflow output. Targets wide datapaths and high-frequency cores where a full-width single-cycle carry chain does not close timing.

## Interface
- WIDTH, 32: operand width; must be a multiple of STAGES.
- STAGES, 2: pipeline depth and carry-segment count, 1..4; SEG = WIDTH/STAGES.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock, single clock domain.
- validIn  in  1  operation presented this cycle.
- stall  in  1  hold every pipeline register.
- flush  in  1  drop all in-flight operations.
- opcode  in  2  00/01 add, 10 add with carryIn, 11 subtract (A + ~B + 1).
- flagMode  in  4  compare select, encoding below.
- flagIn  in  1  flag passed through for unlisted flagMode values.
- carryIn  in  1  carry for opcode 10.
- operantA, operantB  in  WIDTH  operands.
- validOut  out  1  result valid.
- result  out  WIDTH  sum / difference.
- carryOut  out  1  carry out of bit WIDTH-1.
- overflowOut  out  1  signed overflow of the selected operation.
- flagOut  out  1  compare result.

## Operation
- flagMode: 0000 eq, 0001 ne, 0010 gtu, 0011 geu, 0100 ltu, 0101 leu, 1010 gts, 1011 ges, 1100 lts, 1101 les; any other value yields flagIn as captured with the operation.
- Flags compare operantA against the original operantB. They are independent of opcode.
- Effective B: ~operantB for opcode 11, operantB otherwise. Carry into segment 0: 1 for opcode 11, carryIn for opcode 10, 0 otherwise.
- Stage k (0..STAGES-1) adds segment k using the carry registered by stage k-1. Segments k+1 and up of A and effective B travel in skew registers. Finished low segments travel forward with the operation.
- Compare propagation runs from the LSB segment upward:
  - eq = segEq & eqLow.
  - ltu = segLtu | (segEq & ltuLow).
  - The top segment uses a signed compare for the lts path, merged the same way.
- overflowOut = (A[msb] == Beff[msb]) & (result[msb] != A[msb]).
- carryOut for subtract is the raw carry, not a borrow: 1 means A >= B unsigned.
- flagMode, flagIn and opcode-derived controls are captured at entry and travel with the operation.

## Timing
- Latency: exactly STAGES cycles from validIn accepted (stall=0) to validOut. Throughput is one operation per cycle.
- All outputs are registered. STAGES=1 gives a registered equivalent of the single-cycle block.
- stall=1:
  - All data and valid registers hold.
  - Inputs are ignored.
  - Outputs stay stable.
- flush=1: all valid bits clear next edge. Data registers may update. Flush takes priority over stall. An operation presented with flush is dropped.
- reset: all valid bits, result, carryOut, overflowOut, flagOut and internal registers go to 0. Reset mid-operation discards in-flight work. validOut=0 on the first cycle after reset.
- Bubbles (validIn=0) propagate as validOut=0. Data outputs under validOut=0 are don't-care for checking, but must be deterministic.

## Structure
- Package adder_pkg:
  - Opcode constants ADD, ADDC, SUB.
  - flagMode constants: FLAG_EQ, FLAG_NE, FLAG_GTU, FLAG_GEU, FLAG_LTU, FLAG_LEU, FLAG_GTS, FLAG_GES, FLAG_LTS, FLAG_LES.
  - Function decoding flagMode plus (eq, ltu, lts) into flagOut.
- Sub-module adder_segment:
  - Parameter SEG; flag TOP selects the signed compare.
  - Combinational; inputs a, b, beff, cin.
  - Outputs sum, cout, segEq, segLtu, segLts.
  - pipelined_adder instantiates it STAGES times with generate, plus the skew/valid registers.

## Test plan
- WIDTH=32, STAGES=2, single ADD:
  - Input: A=0x0000FFFF, B=0x00000001.
  - Expected after exactly 2 cycles: result=0x00010000, carryOut=0, overflowOut=0. Checks the carry crossing the segment boundary.
- SUB with flagMode=1100 (lts):
  - Input: A=0x80000000, B=0x00000001.
  - Expected: result=0x7FFFFFFF, carryOut=1, overflowOut=1, flagOut=1.
  - Repeat with 0100 (ltu): flagOut=0.
- Back-to-back stream, one operation per cycle:
  - Stream: ADDC with carryIn=1 (0xFFFFFFFF + 0 → 0x00000000, carryOut=1), then eq with A=B=0x1234ABCD → flagOut=1, then flagMode=0111 with flagIn=1 → flagOut=1.
  - Expected: three consecutive validOut pulses in order.
- Control precedence:
  - stall for 3 cycles mid-stream: outputs frozen, no operation lost or duplicated.
  - flush together with stall: validOut=0 for the next 2 cycles.
- Reset with 2 operations in flight: all outputs are 0 next cycle and no stale validOut appears. Repeat the random sweep (10k vectors against a golden model) for STAGES=1, 2, 4.
